// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the programmable tick generator.
package tick_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Programmable tick generator: single-cycle tick every period+1 enabled
// clocks, periodic or one-shot, with run-time loadable period.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int unsigned WIDTH          = 23,
  parameter int unsigned DEFAULT_PERIOD = 32'h007F_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  output logic             tick,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] PERIOD_RST = WIDTH'(DEFAULT_PERIOD);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q,   mode_d;
  logic             tick_q,   tick_d;
  logic             busy_q,   busy_d;

  // Priority is stop, then start, then terminal/increment; load stands apart
  // and the terminal compare always sees the period from before this edge.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    period_d = load ? period_in : period_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
          count_d = '0;
          mode_d  = mode;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else if (start) begin
          count_d = '0;
          mode_d  = mode;
        end else if (enable) begin
          if (count_q >= period_q) begin
            count_d = '0;
            tick_d  = 1'b1;
            if (mode_q == MODE_ONESHOT) state_d = ST_IDLE;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      period_q <= PERIOD_RST;
      mode_q   <= MODE_PERIODIC;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
    end
  end

  assign tick  = tick_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: stimulus queues the edge at which each tick
// must appear, a negedge monitor checks every tick the DUT raises.
module tb_tick_gen;

  localparam int W = 8;
  // 300 truncated to 8 bits is 44
  localparam int DEF_P = 300;
  localparam int DEF_P_TRUNC = 44;

  typedef struct {
    int   edge_n;
    logic busy;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, stop, enable, mode, load;
  logic [W-1:0] period_in;
  logic         tick, busy;
  logic [W-1:0] count;

  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  int   e0;
  exp_t exp_q[$];

  tick_gen #(.WIDTH(W), .DEFAULT_PERIOD(DEF_P)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .enable(enable),
    .mode(mode), .load(load), .period_in(period_in),
    .tick(tick), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectTick(input int edge_n, input logic b);
    exp_t e;
    e.edge_n = edge_n;
    e.busy   = b;
    exp_q.push_back(e);
  endtask

  // Drive start with an optional period load on the same edge; returns edge 0
  task automatic applyStimulus(input logic do_load, input int p, input logic m, output int edge0);
    load      = do_load;
    period_in = W'(p);
    start     = 1'b1;
    mode      = m;
    step();
    edge0     = edge_cnt;
    load      = 1'b0;
    start     = 1'b0;
  endtask

  task automatic doStop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Monitor: each tick pops one expected entry
  always @(negedge clk) begin
    if (reset === 1'b0 && tick !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("[TB] FAIL unexpected_tick: got tick=%b expected none (edge %0d)", tick, edge_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("tick_edge", edge_cnt, e.edge_n);
        checkOutput("tick_busy", {31'd0, busy}, {31'd0, e.busy});
        checkOutput("tick_count", {24'd0, count}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish expected finish within 100000 time units");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; start = 0; stop = 0; enable = 0; mode = 0; load = 0; period_in = '0;
    step(2);
    checkOutput("rst_tick", {31'd0, tick}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_count", {24'd0, count}, 0);
    reset = 1'b0;
    step();

    // Periodic P=3: ticks after edges 4, 8, 12
    load = 1'b1; period_in = 8'd3;
    step();
    load = 1'b0;
    enable = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, e0);
    checkOutput("p3_start_busy", {31'd0, busy}, 1);
    checkOutput("p3_start_count", {24'd0, count}, 0);
    expectTick(e0 + 4, 1'b1);
    expectTick(e0 + 8, 1'b1);
    expectTick(e0 + 12, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 2) checkOutput("p3_count_k", {24'd0, count}, 2);
    end
    checkOutput("p3_busy", {31'd0, busy}, 1);
    doStop();
    checkOutput("stop_busy", {31'd0, busy}, 0);

    // One-shot P=5: single tick after edge 6, busy falls with it
    applyStimulus(1'b1, 5, 1'b1, e0);
    expectTick(e0 + 6, 1'b0);
    step(6);
    checkOutput("os_busy", {31'd0, busy}, 0);
    checkOutput("os_count", {24'd0, count}, 0);
    step(10);
    checkOutput("os_idle_busy", {31'd0, busy}, 0);

    // Periodic P=4 with a 3-cycle enable-low pause after count 2
    applyStimulus(1'b1, 4, 1'b0, e0);
    expectTick(e0 + 8, 1'b1);
    expectTick(e0 + 13, 1'b1);
    step(2);
    enable = 1'b0;
    step(3);
    checkOutput("pause_count", {24'd0, count}, 2);
    enable = 1'b1;
    step(8);
    doStop();

    // P=20 reaches 10, then shrink period to 6
    applyStimulus(1'b1, 20, 1'b0, e0);
    step(10);
    checkOutput("shrink_pre_count", {24'd0, count}, 10);
    load = 1'b1; period_in = 8'd6;
    step();
    load = 1'b0;
    checkOutput("shrink_old_cmp", {24'd0, count}, 11);
    expectTick(e0 + 12, 1'b1);
    expectTick(e0 + 19, 1'b1);
    step(8);
    doStop();

    // start+stop together in RUN: stop wins, no tick
    applyStimulus(1'b0, 0, 1'b0, e0);
    step(2);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checkOutput("ss_busy", {31'd0, busy}, 0);
    checkOutput("ss_count", {24'd0, count}, 0);

    // start alone at the terminal edge restarts without a tick
    applyStimulus(1'b0, 0, 1'b0, e0);
    step(6);
    checkOutput("restart_pre_count", {24'd0, count}, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("restart_count", {24'd0, count}, 0);
    checkOutput("restart_busy", {31'd0, busy}, 1);
    expectTick(e0 + 14, 1'b1);
    step(7);
    doStop();

    // Reset at count 7 with P 7 drops the pending tick
    applyStimulus(1'b1, 7, 1'b0, e0);
    step(7);
    checkOutput("rst_pre_count", {24'd0, count}, 7);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_tick", {31'd0, tick}, 0);
    checkOutput("rst_mid_count", {24'd0, count}, 0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 0);
    step();
    reset = 1'b0;
    step();

    // Period reverted to the truncated default
    applyStimulus(1'b0, 0, 1'b0, e0);
    expectTick(e0 + DEF_P_TRUNC + 1, 1'b1);
    step(DEF_P_TRUNC + 1);
    doStop();
    step(2);

    checkOutput("pending_ticks", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
